// File: rtl/vga_pkg.sv
// vga_pkg: shared types, AXI codes and pixel formatting for the VGA ping-pong fetcher
package vga_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} fetch_state_e;
  typedef enum logic {FMT_RGB444 = 1'b0, FMT_RGB565 = 1'b1} pix_fmt_e;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  function automatic logic [11:0] fmt_pix(input logic mode, input logic [15:0] s);
    return (mode == FMT_RGB565) ? {s[15:12], s[10:7], s[4:1]} : s[11:0];
  endfunction
endpackage

// File: rtl/pp_bank_ram.sv
// pp_bank_ram: two-bank word store, one write port and one registered read port
module pp_bank_ram #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                     clk_v,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk_v) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/vga_pingpong_fetch.sv
// vga_pingpong_fetch: AXI burst reader filling two ping-pong banks drained pixel by pixel
module vga_pingpong_fetch
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 32,
  parameter int PIX_WIDTH  = 16
) (
  input  logic                  clk_v,
  input  logic                  rst_v,
  input  logic                  enable_i,
  input  logic                  mode_i,
  input  logic                  data_req_i,
  output logic [11:0]           data_o,
  output logic                  underflow_o,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] top_addr_i,
  input  logic                  arready_i,
  output logic                  arvalid_o,
  output logic [ADDR_WIDTH-1:0] araddr_o,
  output logic [1:0]            arburst_o,
  output logic [7:0]            arlen_o,
  output logic [2:0]            arsize_o,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            rresp_i,
  input  logic                  rlast_i,
  output logic                  err_o
);
  localparam int PPW = DATA_WIDTH / PIX_WIDTH;
  localparam int CW  = $clog2(BURST_LEN);
  localparam int SW  = PPW > 1 ? $clog2(PPW) : 1;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
  fetch_state_e r_state, w_next;
  logic [1:0] r_valid;
  logic r_wbank, r_rbank, r_first, r_show, r_mode, r_uf, r_err;
  logic [CW-1:0] r_wcnt, r_rword;
  logic [SW-1:0] r_rslot, r_slot_q;
  logic [ADDR_WIDTH-1:0] r_addr, w_inc;
  logic w_beat, w_final, w_acc, w_idle_off, w_last_slot;
  logic [DATA_WIDTH-1:0] w_q;
  logic [15:0] w_pix;

  assign w_beat      = r_state == ST_DATA && rvalid_i;
  assign w_final     = w_beat && (rlast_i || r_wcnt == CW'(BURST_LEN - 1));
  assign w_acc       = data_req_i && r_valid[r_rbank];
  assign w_idle_off  = r_state == ST_IDLE && !enable_i;
  assign w_last_slot = r_rword == CW'(BURST_LEN - 1) && r_rslot == SW'(PPW - 1);
  assign w_inc       = r_addr + STEP;
  assign w_pix       = 16'(w_q[r_slot_q*PIX_WIDTH +: PIX_WIDTH]);

  pp_bank_ram #(.DEPTH(2 * BURST_LEN), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk_v   (clk_v),
    .i_we    (w_beat),
    .i_waddr ({r_wbank, r_wcnt}),
    .i_wdata (rresp_i == AXI_RESP_OKAY ? rdata_i : '0),
    .i_re    (w_acc),
    .i_raddr ({r_rbank, r_rword}),
    .o_rdata (w_q)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (enable_i && !r_valid[r_wbank]) w_next = ST_ADDR;
      ST_ADDR: if (arready_i) w_next = ST_DATA;
      ST_DATA: if (w_final) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_v or posedge rst_v)
    if (rst_v) r_state <= ST_IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk_v or posedge rst_v) begin
    if (rst_v) begin
      r_valid  <= '0;
      r_wbank  <= 1'b0;
      r_rbank  <= 1'b0;
      r_first  <= 1'b1;
      r_show   <= 1'b0;
      r_mode   <= 1'b0;
      r_uf     <= 1'b0;
      r_err    <= 1'b0;
      r_wcnt   <= '0;
      r_rword  <= '0;
      r_rslot  <= '0;
      r_slot_q <= '0;
      r_addr   <= '0;
    end else begin
      r_uf <= data_req_i && !r_valid[r_rbank];
      if (data_req_i) begin
        r_show   <= w_acc;
        r_slot_q <= r_rslot;
        r_mode   <= mode_i;
      end
      if (w_beat && rresp_i != AXI_RESP_OKAY) r_err <= 1'b1;
      if (w_idle_off) begin
        r_valid <= '0;
        r_wbank <= 1'b0;
        r_rbank <= 1'b0;
        r_wcnt  <= '0;
        r_rword <= '0;
        r_rslot <= '0;
        r_addr  <= base_addr_i;
        r_first <= 1'b1;
      end else begin
        // first burst after reset or disable always restarts at the frame base
        if (r_state == ST_IDLE && w_next == ST_ADDR && r_first) begin
          r_addr  <= base_addr_i;
          r_first <= 1'b0;
        end
        if (r_state == ST_ADDR && arready_i) r_addr <= w_inc >= top_addr_i ? base_addr_i : w_inc;
        if (w_beat) r_wcnt <= w_final ? '0 : r_wcnt + 1'b1;
        if (w_final) r_wbank <= ~r_wbank;
        if (w_acc) begin
          r_rslot <= r_rslot == SW'(PPW - 1) ? '0 : r_rslot + 1'b1;
          if (r_rslot == SW'(PPW - 1)) r_rword <= r_rword + 1'b1;
          if (w_last_slot) r_rbank <= ~r_rbank;
        end
        r_valid <= (r_valid | (w_final ? 2'b01 << r_wbank : 2'b00))
                 & ~((w_acc && w_last_slot) ? 2'b01 << r_rbank : 2'b00);
      end
    end
  end

  assign arvalid_o   = r_state == ST_ADDR;
  assign araddr_o    = r_addr;
  assign arburst_o   = arvalid_o ? AXI_BURST_INCR : 2'b00;
  assign arlen_o     = arvalid_o ? 8'(BURST_LEN - 1) : 8'd0;
  assign arsize_o    = arvalid_o ? 3'($clog2(DATA_WIDTH / 8)) : 3'd0;
  assign rready_o    = r_state == ST_DATA;
  assign underflow_o = r_uf;
  assign err_o       = r_err;
  assign data_o      = r_show ? fmt_pix(r_mode, w_pix) : 12'd0;
endmodule

// File: doc/vga_pingpong_fetch.md
VGA_PINGPONG_FETCH -- requirements
Module: vga_pingpong_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, AXI data width; one of 32, 64 or 128.
REQ-003 SHALL have parameter BURST_LEN, default 32, beats per burst and words per bank; power of two, 2..256.
REQ-004 SHALL have parameter PIX_WIDTH, default 16, stored bits per pixel; it divides DATA_WIDTH. PPW = DATA_WIDTH/PIX_WIDTH.
REQ-005 SHALL use a single clock and reset: clk_v in 1 is the only clock; rst_v in 1 is an asynchronous, active-high reset.
REQ-006 SHALL have the following VGA-side ports:
- enable_i in 1: fetch enable.
- mode_i in 1: 0 = RGB444, 1 = RGB565.
- data_req_i in 1: pixel request.
- data_o out 12: RGB444 pixel.
- underflow_o out 1: one-cycle pulse on an underflow.
REQ-007 SHALL have the following config ports:
- base_addr_i in ADDR_WIDTH: frame start, burst-aligned.
- top_addr_i in ADDR_WIDTH: frame end, exclusive.
REQ-008 SHALL have the following AXI read ports:
- arready_i in 1.
- arvalid_o out 1.
- araddr_o out ADDR_WIDTH.
- arburst_o out 2.
- arlen_o out 8.
- arsize_o out 3.
- rvalid_i in 1.
- rready_o out 1.
- rdata_i in DATA_WIDTH.
- rresp_i in 2.
- rlast_i in 1.
- err_o out 1: sticky error flag.

Function
REQ-009 SHALL hold two banks of BURST_LEN x DATA_WIDTH words, each with a valid bit, plus a write-bank pointer and a read-bank pointer.
REQ-010 SHALL run a fetch FSM with states IDLE, ADDR and DATA:
- IDLE -> ADDR when enable_i=1 and the write bank is invalid.
- ADDR -> DATA on arvalid_o & arready_i.
- DATA -> IDLE on the final beat.
REQ-011 SHALL, in ADDR, assert arvalid_o and hold araddr_o stable until arready_i is sampled high, with:
- arburst_o = 2'b01 (INCR).
- arlen_o = BURST_LEN-1.
- arsize_o = log2(DATA_WIDTH/8).
REQ-012 SHALL hold rready_o=1 in DATA only; each beat with rvalid_i & rready_o is written to write bank word wcnt, and wcnt increments.
REQ-013 SHALL treat the final beat as rlast_i=1 or wcnt=BURST_LEN-1, whichever comes first. On the final beat:
- Set the write bank valid.
- Toggle the write-bank pointer.
- Clear wcnt.
REQ-014 SHALL compute the next address as araddr + BURST_LEN*DATA_WIDTH/8; if the result is >= top_addr_i, the next address SHALL be base_addr_i instead (wrap).
REQ-015 SHALL, for a beat with rresp_i != 2'b00, store zero instead of rdata_i and set err_o; err_o is cleared only by reset.
REQ-016 SHALL, when enable_i falls mid-burst, complete the burst, then stay in IDLE.
REQ-017 SHALL, while enable_i=0 and the FSM is in IDLE, do the following every cycle:
- Invalidate both banks.
- Zero both bank pointers and all counters.
- Load the fetch address from base_addr_i.
REQ-018 SHALL, on data_req_i=1 with the read bank valid, register the pixel at word rword, slot rslot into data_o on the next edge (latency 1).
REQ-019 SHALL advance the read position as follows:
- rslot increments on every accepted request.
- rword increments when rslot wraps at PPW-1.
- When rword=BURST_LEN-1 and rslot=PPW-1, clear the read bank valid bit and toggle the read-bank pointer.
REQ-020 SHALL format pixels as follows:
- mode_i=0: data_o = slot bits [11:0].
- mode_i=1: data_o = {s[15:12], s[10:7], s[4:1]}.
- When PIX_WIDTH < 16, missing bits read as zero.
REQ-021 SHALL, on data_req_i=1 with the read bank invalid:
- Set data_o to 0.
- Pulse underflow_o for one cycle.
- Hold the read pointers.
REQ-022 SHALL use the registered valid bits for IDLE -> ADDR. A valid bit cleared by the reader in cycle N allows ADDR no earlier than N+1. Reader and writer never access the same bank in the same cycle.

Reset
REQ-023 SHALL, on rst_v=1 (asynchronous), drive:
- arvalid_o=0, rready_o=0, underflow_o=0, err_o=0.
- data_o=0, araddr_o=0, arburst_o=0, arlen_o=0, arsize_o=0.
- FSM in IDLE, both banks invalid, all pointers and counters 0.
REQ-024 SHALL discard any in-flight burst on reset; bank contents need not be cleared.

Structure
REQ-025 SHALL define the following in shared package vga_pkg:
- Fetch state enum.
- AXI_BURST_INCR=2'b01.
- AXI_RESP_OKAY=2'b00.
- Pixel format codes.
REQ-026 SHALL instantiate the bank storage as one sub-module, pp_bank_ram (2*BURST_LEN x DATA_WIDTH, one write port, one registered read port).

Verification
REQ-027 SHALL cover fill and drain. Stimulus: defaults, base=0x1000, top=0x2000, arready=1, then 128 requests. Required response: araddr_o=0x1000, then 0x1100; arlen_o=0x1F, arsize_o=3; data_o reproduces the slots in order, one cycle after each request.
REQ-028 SHALL cover address wrap. Stimulus: base=0x1000, top=0x1200. Required response: the third burst address is 0x1000.
REQ-029 SHALL cover underflow. Stimulus: a request before the first burst completes. Required response: data_o=0, a one-cycle underflow_o, pointers unchanged.
REQ-030 SHALL cover error handling. Stimulus: beat 5 with rresp=2'b10. Required response: err_o=1 and stays 1; the pixels of word 5 read as 0.
REQ-031 SHALL cover handshake stall. Stimulus: arready held low for 10 cycles. Required response: arvalid_o stays high and araddr_o stable; a mid-DATA enable drop finishes all 32 beats.
REQ-032 SHALL cover reset mid-burst. Stimulus: rst_v at beat 7, then rst_v=0. Required response: all outputs 0; the next burst starts at base_addr_i.
